// File: rtl/sim_proc_pkg.sv
// Shared types for the host-side memory sequencer: command opcodes,
// sequencer states and default memory geometry.
package sim_proc_pkg;

  localparam int unsigned ADDR_W_DEF = 9;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    OP_LOAD_I = 2'b00,
    OP_LOAD_D = 2'b01,
    OP_RUN    = 2'b10,
    OP_READ_D = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ZERO,
    S_W_WAIT,
    S_W_SETUP,
    S_W_STROBE,
    S_W_NEXT,
    S_R_REQ,
    S_R_WAIT,
    S_R_OUT,
    S_RUN
  } state_e;

endpackage

// File: rtl/mem_word_counter.sv
// Address register plus remaining-word down-counter, shared by the load
// and readback paths. Address wraps modulo 2**ADDR_W.
module mem_word_counter #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_remaining;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (load) begin
      r_addr      <= base;
      r_remaining <= count;
    end else if (step) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - ADDR_W'(1);
    end
  end

  assign addr = r_addr;
  // Sampled before the step: the word being finished is the final one.
  assign last = (r_remaining == ADDR_W'(1));

endmodule

// File: rtl/host_mem_sequencer.sv
// Handshaked host sequencer for the simple processor: IRAM/DRAM load,
// program run with timeout, and DRAM readback. One mode active at a time.
module host_mem_sequencer
  import sim_proc_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned RUN_TIMEOUT = 120000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              core_done,
  output logic              start,
  output logic              start_2,
  output logic              start_3,
  output logic              start_4,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              iram_write_ext,
  output logic              dram_write_ext,
  output logic              dram_read_ext,
  output logic [DATA_W-1:0] Data_in_ins,
  output logic [DATA_W-1:0] Data_in_dram,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int unsigned TW = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [DATA_W-1:0] r_data_ins;
  logic [DATA_W-1:0] r_data_dram;
  logic [DATA_W-1:0] r_rd_data;
  logic [LW-1:0]     r_lat;
  logic [TW-1:0]     r_tmo;
  logic              r_timeout_err;

  logic              w_active;
  logic              w_cmd_fire;
  logic              w_wr_fire;
  logic              w_lat_done;
  logic              w_tmo_hit;
  logic              w_ctr_load;
  logic              w_ctr_step;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr;

  assign w_cmd_fire = cmd_valid && (r_state == S_IDLE);
  assign w_wr_fire  = wr_valid && (r_state == S_W_WAIT);
  assign w_lat_done = (r_lat == LW'(READ_LAT - 1));
  assign w_tmo_hit  = (r_tmo == TW'(RUN_TIMEOUT - 1));
  assign w_ctr_load = w_cmd_fire && (cmd_op != OP_RUN);
  assign w_ctr_step = (r_state == S_W_NEXT) || ((r_state == S_R_OUT) && rd_ready);

  mem_word_counter #(
    .ADDR_W (ADDR_W)
  ) u_word_ctr (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (w_ctr_load),
    .step    (w_ctr_step),
    .base    (cmd_base),
    .count   (cmd_count),
    .addr    (w_addr),
    .last    (w_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    rd_valid       = 1'b0;
    iram_write_ext = 1'b0;
    dram_write_ext = 1'b0;
    dram_read_ext  = 1'b0;
    w_active       = (r_state != S_IDLE);
    busy           = w_active;
    // Mode lines follow the latched op for the whole non-idle span.
    start          = w_active && (r_op == OP_RUN);
    start_2        = w_active && (r_op == OP_LOAD_I);
    start_3        = w_active && (r_op == OP_LOAD_D);
    start_4        = w_active && (r_op == OP_READ_D);
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_RUN)          w_next = S_RUN;
          else if (cmd_count == '0)      w_next = S_ZERO;
          else if (cmd_op == OP_READ_D)  w_next = S_R_REQ;
          else                           w_next = S_W_WAIT;
        end
      end
      S_ZERO:     w_next = S_IDLE;
      S_W_WAIT: begin
        wr_ready = 1'b1;
        if (wr_valid) w_next = S_W_SETUP;
      end
      S_W_SETUP:  w_next = S_W_STROBE;
      S_W_STROBE: begin
        iram_write_ext = (r_op == OP_LOAD_I);
        dram_write_ext = (r_op == OP_LOAD_D);
        w_next         = S_W_NEXT;
      end
      S_W_NEXT:   w_next = w_last ? S_IDLE : S_W_WAIT;
      S_R_REQ: begin
        dram_read_ext = 1'b1;
        w_next        = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (w_lat_done) w_next = S_R_OUT;
      end
      S_R_OUT: begin
        rd_valid = 1'b1;
        if (rd_ready) w_next = w_last ? S_IDLE : S_R_REQ;
      end
      S_RUN: begin
        if (core_done || w_tmo_hit) w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op          <= OP_LOAD_I;
      r_data_ins    <= '0;
      r_data_dram   <= '0;
      r_rd_data     <= '0;
      r_lat         <= '0;
      r_tmo         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_op          <= op_e'(cmd_op);
        r_timeout_err <= 1'b0;
      end
      if (w_wr_fire) begin
        if (r_op == OP_LOAD_I) r_data_ins  <= wr_data;
        else                   r_data_dram <= wr_data;
      end
      if (r_state == S_R_WAIT) begin
        r_lat <= r_lat + LW'(1);
        if (w_lat_done) r_rd_data <= mem_rd_data;
      end else begin
        r_lat <= '0;
      end
      // A core_done coinciding with the last allowed cycle counts as success.
      if (r_state == S_RUN) begin
        r_tmo <= r_tmo + TW'(1);
        if (w_tmo_hit && !core_done) r_timeout_err <= 1'b1;
      end else begin
        r_tmo <= '0;
      end
    end
  end

  assign addr_ext     = w_addr;
  assign Data_in_ins  = r_data_ins;
  assign Data_in_dram = r_data_dram;
  assign rd_data      = r_rd_data;
  assign timeout_err  = r_timeout_err;

endmodule
